// File: rtl/comproc_mem_pkg.sv
// Shared types and constants for the data-memory side of the processor:
// arbiter state encoding, reserved addresses and requester identifiers.
package comproc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Reserved addresses, also used by the I/O decoder.
    localparam logic [7:0] ADDR_NULL = 8'h00;
    localparam logic [7:0] ADDR_UART = 8'h01;

    typedef logic [0:0] req_id_t;

    // One-hot completion vector for a requester id.
    function automatic logic [1:0] id_onehot(input req_id_t id);
        logic [1:0] vec;
        if (id == 1'b1) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_pick2
    import comproc_mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic       grant_valid,
    output req_id_t    grant_id
);

    // Choose the winner from the current request vector and grant history.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (req)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single data-memory port between the CPU load/store path
// (requester 0) and a secondary master (requester 1). One transaction at a
// time, round-robin on contention, address 00h is never written and reads
// back as 00h.
module mem_bus_arbiter
    import comproc_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W     = 2;
    localparam logic [CNT_W-1:0]  LAT_INIT  = CNT_W'(RD_LATENCY);
    localparam logic [ADDR_W-1:0] NULL_ADDR = ADDR_W'(ADDR_NULL);

    arb_state_t        state_r;
    req_id_t           last_grant_r;
    req_id_t           grant_id_r;
    logic              lat_we_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        ack_r;
    logic [DATA_W-1:0] rdata_r;
    logic              busy_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_wr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic              pick_valid_s;
    req_id_t           pick_id_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_we_s;

    rr_pick2 u_pick (
        .req         (req),
        .last_grant  (last_grant_r),
        .grant_valid (pick_valid_s),
        .grant_id    (pick_id_s)
    );

    // Route the would-be winner's address, data and direction to the latch.
    always_comb begin
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        sel_we_s    = we[0];
        if (pick_id_s == 1'b1) begin
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
            sel_we_s    = we[1];
        end else begin
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
            sel_we_s    = we[0];
        end
    end

    // Transaction FSM; mem_addr_r doubles as the latched request address and
    // is driven to the memory straight from the grant edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
            lat_we_r     <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            ack_r        <= 2'b00;
            rdata_r      <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wr_r     <= 1'b0;
            mem_wdata_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_r      <= ACCESS;
                        busy_r       <= 1'b1;
                        grant_id_r   <= pick_id_s;
                        last_grant_r <= pick_id_s;
                        lat_we_r     <= sel_we_s;
                        mem_addr_r   <= sel_addr_s;
                        mem_wdata_r  <= sel_wdata_s;
                        mem_wr_r     <= sel_we_s && (sel_addr_s != NULL_ADDR);
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ACCESS: begin
                    mem_wr_r <= 1'b0;
                    if (lat_we_r) begin
                        state_r <= RESP;
                        ack_r   <= id_onehot(grant_id_r);
                    end else begin
                        state_r <= WAIT;
                        cnt_r   <= LAT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == 2'd1) begin
                        state_r <= RESP;
                        ack_r   <= id_onehot(grant_id_r);
                        if (mem_addr_r == NULL_ADDR) begin
                            rdata_r <= {DATA_W{1'b0}};
                        end else begin
                            rdata_r <= mem_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    ack_r   <= 2'b00;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    ack_r    <= 2'b00;
                    busy_r   <= 1'b0;
                    mem_wr_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wr    = mem_wr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level reference model
// predicts write strobes and acks from the driven inputs; a monitor pops and
// compares whenever the DUT presents an ack or a write strobe.
module tb_mem_bus_arbiter;

    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] ack;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int cyc; int id; bit rd; logic [7:0] data; } ack_ev_t;
    typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } wr_ev_t;

    ack_ev_t    ack_q[$];
    wr_ev_t     wr_q[$];
    logic [7:0] ram[256];
    logic [7:0] ref_mem[256];
    int         m_last = 1;
    int         m_free = 0;
    int         m_blo  = 1;
    int         m_bhi  = 0;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 73 + 19);
        if (i == 0)  v = 8'hFF;
        if (i == 64) v = 8'h3C;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ack"},       {30'd0, ack},    32'd0);
        check({tag, "_rdata"},     {24'd0, rdata},  32'd0);
        check({tag, "_mem_addr"},  {24'd0, mem_addr}, 32'd0);
        check({tag, "_mem_wr"},    {31'd0, mem_wr}, 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},   32'd0);
    endtask

    // Memory device: registered read port, writes on mem_wr.
    initial begin : ram_dev
        for (int i = 0; i < 256; i++) ram[i] = init_val(i);
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_wr === 1'b1) ram[mem_addr] = mem_wdata;
        end
    end

    // Reference model: serial transactions, round-robin ties, null-address rules.
    initial begin : model
        ack_ev_t    ae;
        wr_ev_t     wev;
        int         w;
        int         dur;
        logic [7:0] a;
        logic [7:0] d;
        bit         wr;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (rst !== 1'b1) begin
                ack_q.delete();
                wr_q.delete();
                m_last = 1;
                m_free = cyc + 1;
                m_blo  = 1;
                m_bhi  = 0;
            end else if (cyc >= m_free && req != 2'b00) begin
                if (req == 2'b11) w = 1 - m_last;
                else if (req[1])  w = 1;
                else              w = 0;
                a   = (w == 1) ? addr1  : addr0;
                d   = (w == 1) ? wdata1 : wdata0;
                wr  = (w == 1) ? we[1]  : we[0];
                dur = wr ? 2 : 2 + RD_LAT;
                if (wr && a != 8'h00) begin
                    wev.cyc = cyc + 1; wev.a = a; wev.d = d;
                    wr_q.push_back(wev);
                    ref_mem[a] = d;
                end
                ae.cyc  = cyc + dur;
                ae.id   = w;
                ae.rd   = !wr;
                ae.data = (a == 8'h00) ? 8'h00 : ref_mem[a];
                ack_q.push_back(ae);
                m_last = w;
                m_free = cyc + dur + 1;
                m_blo  = cyc + 1;
                m_bhi  = cyc + dur;
            end
            cyc++;
        end
    end

    // Monitor: compare busy every cycle; pop on every ack and write strobe.
    initial begin : monitor
        ack_ev_t e;
        wr_ev_t  x;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("busy", {31'd0, busy}, {31'd0, (cyc >= m_blo && cyc <= m_bhi)});
                if (ack !== 2'b00) begin
                    if (ack_q.size() == 0) begin
                        check("ack_spurious", {30'd0, ack}, 32'd0);
                    end else begin
                        e = ack_q.pop_front();
                        check("ack_cycle", cyc, e.cyc);
                        check("ack_id", {30'd0, ack}, (e.id == 1) ? 32'd2 : 32'd1);
                        if (e.rd) check("rdata", {24'd0, rdata}, {24'd0, e.data});
                    end
                end else if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                    e = ack_q.pop_front();
                    check("ack_missing", {30'd0, ack}, (e.id == 1) ? 32'd2 : 32'd1);
                end
                if (mem_wr !== 1'b0) begin
                    if (wr_q.size() == 0) begin
                        check("mem_wr_spurious", {31'd0, mem_wr}, 32'd0);
                    end else begin
                        x = wr_q.pop_front();
                        check("wr_cycle", cyc, x.cyc);
                        check("wr_addr", {24'd0, mem_addr}, {24'd0, x.a});
                        check("wr_data", {24'd0, mem_wdata}, {24'd0, x.d});
                    end
                end else if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                    void'(wr_q.pop_front());
                    check("mem_wr_missing", {31'd0, mem_wr}, 32'd1);
                end
            end
        end
    end

    // Stimulus: directed test-plan scenarios, then randomized traffic.
    initial begin : driver
        rst = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b1;
        tick();

        // Single write; address changed after the grant must be ignored.
        req = 2'b01; we = 2'b01; addr0 = 8'h20; wdata0 = 8'h5A;
        tick();
        addr0 = 8'h30;
        tick();
        req = 2'b00;
        check("hold_mem_addr", {24'd0, mem_addr}, 32'h20);
        check("hold_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
        tick();

        // Null write, then null read with req dropped during WAIT.
        req = 2'b01; we = 2'b01; addr0 = 8'h00; wdata0 = 8'h77;
        repeat (2) tick();
        req = 2'b00; tick();
        req = 2'b01; we = 2'b00; addr0 = 8'h00;
        repeat (2) tick();
        req = 2'b00;
        repeat (2) tick();

        // Single read by requester 1.
        req = 2'b10; we = 2'b00; addr1 = 8'h40;
        tick();
        req = 2'b00;
        repeat (4) tick();

        // Continuous contention, both reading.
        req = 2'b11; we = 2'b00; addr0 = 8'h10; addr1 = 8'h40;
        repeat (16) tick();
        req = 2'b00;
        repeat (4) tick();

        // Reset during WAIT, then a tie must go to requester 0.
        req = 2'b10; we = 2'b00; addr1 = 8'h40;
        repeat (2) tick();
        rst = 1'b0; req = 2'b00;
        tick();
        check_reset("mid_reset");
        rst = 1'b1;
        req = 2'b11; we = 2'b11;
        addr0 = 8'h50; wdata0 = 8'hA1; addr1 = 8'h51; wdata1 = 8'hB2;
        repeat (6) tick();
        req = 2'b00;
        repeat (3) tick();

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            req    = 2'($urandom_range(0, 3));
            we     = 2'($urandom_range(0, 3));
            addr0  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 15));
            addr1  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 15));
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            tick();
        end
        rst = 1'b1; req = 2'b00;
        repeat (10) tick();
        check("ack_queue_drained", ack_q.size(), 32'd0);
        check("wr_queue_drained", wr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit data memory port between two requesters: requester 0 is the CPU load/store path, requester 1 is a secondary master such as a program loader or debug port.
- Each requester uses a req/ack handshake. Only one transaction is outstanding at a time.
- Grants alternate round-robin on contention.
- Sits between the masters and the data RAM / memory-mapped I/O decode. Address 00h is the null address and is protected.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- RD_LATENCY, 1, cycles from mem_addr valid to mem_rdata valid; legal values 1..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req  in  2  per-requester transaction request; bit i belongs to requester i.
- we  in  2  per-requester write enable, qualified by req[i].
- addr0, addr1  in  ADDR_W  requester address.
- wdata0, wdata1  in  DATA_W  requester write data.
- ack  out  2  one-cycle completion pulse per requester.
- rdata  out  DATA_W  read data; valid while any ack bit is 1.
- busy  out  1  a transaction is in progress (state != IDLE).
- mem_addr  out  ADDR_W  memory address.
- mem_wr  out  1  memory write strobe, one cycle.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - ack=0, rdata=0, mem_addr=0, mem_wr=0, mem_wdata=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-transaction aborts the transaction: no ack, and mem_wr is 0 from the next cycle.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - If exactly one req bit is set, grant that requester.
  - If both req bits are set, grant the requester != last_grant.
  - On grant: latch the winner's addr/we/wdata into internal registers, set last_grant to the winner, go to ACCESS.
- ACCESS (1 cycle):
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_wr = latched_we AND (latched_addr != 00h).
  - Write: go to RESP.
  - Read: go to WAIT with counter = RD_LATENCY.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture mem_rdata into rdata (00h if latched_addr == 00h), then go to RESP.
- RESP (1 cycle):
  - ack[grantee] = 1; rdata is held stable.
  - Go to IDLE.
- Latency, with req sampled in IDLE at cycle N:
  - Write: mem_wr high in N+1, ack in N+2.
  - Read: mem_addr valid from N+1, ack in N+2+RD_LATENCY (N+3 at default).
- mem_addr and mem_wdata hold their last value outside ACCESS; they do not return to 0.
- mem_wr is high only in ACCESS, for exactly one cycle per write.
- Write to 00h: no mem_wr pulse, still acked.
- Read from 00h: returns 00h, memory value ignored.
- Requester rules:
  - A requester holds req and its addr/we/wdata stable until ack.
  - Inputs are sampled only in IDLE; changes after the grant are ignored.
  - Dropping req after the grant does not cancel the transaction; ack is still issued.
- req still high in the cycle after ack (IDLE) is a new transaction. It is arbitrated normally, so a contender gets in.
- Round-robin guarantee: under continuous contention grants strictly alternate 0,1,0,1,... No requester waits more than one foreign transaction.
- ack bits are never both 1; ack is never asserted outside RESP.
- busy = (state != IDLE).

Decomposition:
- Package comproc_mem_pkg holds:
  - enum arb_state_t {IDLE, ACCESS, WAIT, RESP}.
  - localparam ADDR_NULL = 8'h00 and ADDR_UART = 8'h01, shared with the I/O decoder.
  - typedef logic [0:0] req_id_t.
- Sub-module rr_pick2: combinational round-robin selector. Inputs are req[1:0] and last_grant; outputs are grant_valid and grant_id. It is instantiated once.

Test Plan:
- Single write: req=01, we=01, addr0=20h, wdata0=5Ah at cycle N -> mem_wr=1 with mem_addr=20h and mem_wdata=5Ah in N+1 only; ack=01 in N+2.
- Single read, RD_LATENCY=1: memory returns 3Ch at 40h; req=10, addr1=40h -> ack=10 in N+3, rdata=3Ch, busy low in N+4.
- Contention: both req held continuously after reset, both reads -> grant order 0,1,0,1; ack alternates 01,10,01,10; each transaction completes in 4 cycles.
- Null address: write 77h to 00h -> mem_wr stays 0 throughout, ack=01. Read 00h with mem_rdata=FFh -> rdata=00h.
- Reset mid-read: rst=0 during WAIT -> next cycle state IDLE, ack=00, rdata=00h, mem_wr=0. A new req after rst=1 is served starting with requester 0 on a tie.
- Input change after grant: addr0 switched 20h->30h in ACCESS -> mem_addr stays 20h. Dropping req0 in WAIT -> ack=01 is still issued.
